// File: rtl/hazard_fwd_if.sv
// Bundle between the ID stage and the hazard/forwarding unit: ID-stage instruction
// fields and flush go in, while the EX operand selects, the stall and the stall count come out.
interface hazard_fwd_if #(
    parameter int REG_W = 5
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_wr_en;
    logic [REG_W-1:0] id_wr_reg;
    logic             id_is_load;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic [15:0]      stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_wr_en, id_wr_reg, id_is_load, flush,
        input  fwd_a_sel, fwd_b_sel, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_wr_en, id_wr_reg, id_is_load, flush,
        output fwd_a_sel, fwd_b_sel, stall, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: tracks shadow EX/MEM/WB(/PWB) writer state, produces operand forwarding
// selects, a load-use stall and a saturating stall count. FWD_PWB_BYPASS_EN adds the PWB source.
module hazard_fwd_unit #(
    parameter int REG_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_fwd_if.slave hz
);
`ifdef FWD_PWB_BYPASS_EN
    localparam int NSTG = 3;
`else
    localparam int NSTG = 2;
`endif

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] wr_reg;
        logic             is_load;
    } stage_t;

    // EX stage (also carries the source registers it will read)
    stage_t           ex_q,    ex_d;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;

    // Downstream writers: index 0 = MEM, 1 = WB, 2 = PWB (bypass build only)
    stage_t           pipe_q [NSTG];
    stage_t           pipe_d [NSTG];
    logic [NSTG-1:0]  qual;

    logic [15:0]      stall_cnt_q, stall_cnt_d;
    logic             stall_w;
    logic [1:0][1:0]  sel_all;
    logic [1:0][REG_W-1:0] src_all;

    assign stall_w = hz.id_valid && !hz.flush &&
                     ex_q.valid && ex_q.is_load && ex_q.wr_en && (ex_q.wr_reg != '0) &&
                     ((ex_q.wr_reg == hz.id_rs) || (ex_q.wr_reg == hz.id_rt));

    always_comb begin
        ex_d    = '0;
        ex_rs_d = '0;
        ex_rt_d = '0;
        if (!stall_w && !hz.flush) begin
            ex_d.valid   = hz.id_valid;
            ex_d.wr_en   = hz.id_wr_en;
            ex_d.wr_reg  = hz.id_wr_reg;
            ex_d.is_load = hz.id_is_load;
            ex_rs_d      = hz.id_rs;
            ex_rt_d      = hz.id_rt;
        end
    end

    assign stall_cnt_d = (stall_w && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

    // Downstream stages advance every cycle; a stall only affects what EX captures
    assign pipe_d[0] = ex_q;
    genvar gi;
    generate
        for (gi = 1; gi < NSTG; gi++) begin : g_shift
            assign pipe_d[gi] = pipe_q[gi-1];
        end
        for (gi = 0; gi < NSTG; gi++) begin : g_qual
            assign qual[gi] = pipe_q[gi].valid && pipe_q[gi].wr_en && (pipe_q[gi].wr_reg != '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < NSTG; i++) pipe_q[i] <= '0;
        end else begin
            ex_q        <= ex_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < NSTG; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign src_all[0] = ex_rs_q;
    assign src_all[1] = ex_rt_q;

    // Scan oldest to youngest so the nearest matching writer wins; select code is stage index + 1
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic [1:0] sel_next;
            always_comb begin
                sel_next = 2'b00;
                for (int s = NSTG - 1; s >= 0; s--) begin
                    if (qual[s] && (pipe_q[s].wr_reg == src_all[gi])) begin
                        sel_next = 2'(s + 1);
                    end
                end
                if (!ex_q.valid) begin
                    sel_next = 2'b00;
                end
            end
            assign sel_all[gi] = sel_next;
        end
    endgenerate

    assign hz.fwd_a_sel = sel_all[0];
    assign hz.fwd_b_sel = sel_all[1];
    assign hz.stall     = stall_w;
    assign hz.stall_cnt = stall_cnt_q;
endmodule
